// File: rtl/nibble_serial_tx.sv
// nibble_serial_tx
// Takes a DATA_W-bit word over a valid/ready handshake and sends it out
// serially as one frame: a start bit (0), the data bits LSB first, then a
// stop bit (1). Each bit is held for CLKS_PER_BIT clock cycles. This is the
// sending end of the D-register data path.
//
// Ports
//   clk      rising-edge clock
//   reset    asynchronous active-low reset (0 = reset)
//   enable   clock enable; 0 freezes the frame in progress
//   d_in     word to send, sampled only on an accepting handshake
//   d_valid  sender has a word on d_in
//   d_ready  block can accept a word (combinational)
//   tx       registered serial line, idles high
//   busy     a frame is in progress (START/DATA/STOP)
//   done     one-cycle pulse after a frame completes
module nibble_serial_tx #(
  parameter int DATA_W       = 4,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [DATA_W-1:0] d_in,
  input  logic              d_valid,
  output logic              d_ready,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  // Counter widths collapse to one bit when the range is a single value.
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic [IW-1:0]     idx, idx_nxt;
  logic [DATA_W-1:0] shift, shift_nxt;
  logic [DATA_W-1:0] shifted;
  logic              tx_nxt;
  logic              done_nxt;
  logic              last_cnt;

  // Ready is a pure function of reset, enable and state so a sender may wait
  // on it without creating a loop through d_valid.
  assign d_ready  = reset & enable & (state == IDLE);
  assign busy     = (state != IDLE);
  assign last_cnt = (cnt == CW'(CLKS_PER_BIT - 1));

  // State register. Everything resets asynchronously; tx is kept as a
  // register so the pin never sees a combinational glitch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shift <= '0;
      tx    <= 1'b1;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
      shift <= shift_nxt;
      tx    <= tx_nxt;
      done  <= done_nxt;
    end
  end

  // Next-state logic. The defaults hold everything and clear done, which is
  // exactly the behaviour needed when enable is low. tx_nxt always carries
  // the line level belonging to the state being entered, so a bit becomes
  // visible on the same edge that starts it.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    shift_nxt = shift;
    tx_nxt    = tx;
    done_nxt  = 1'b0;
    shifted   = shift >> 1;

    if (enable) begin
      case (state)
        IDLE: begin
          tx_nxt = 1'b1;
          if (d_valid && d_ready) begin
            shift_nxt = d_in;
            cnt_nxt   = '0;
            idx_nxt   = '0;
            tx_nxt    = 1'b0;
            state_nxt = START;
          end
        end

        START: begin
          if (last_cnt) begin
            cnt_nxt   = '0;
            idx_nxt   = '0;
            tx_nxt    = shift[0];
            state_nxt = DATA;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end

        // At each data bit boundary the register shifts right and the new
        // LSB goes straight to the line.
        DATA: begin
          if (last_cnt) begin
            cnt_nxt = '0;
            if (idx == IW'(DATA_W - 1)) begin
              tx_nxt    = 1'b1;
              state_nxt = STOP;
            end else begin
              idx_nxt   = idx + IW'(1);
              shift_nxt = shifted;
              tx_nxt    = shifted[0];
            end
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end

        STOP: begin
          if (last_cnt) begin
            cnt_nxt   = '0;
            tx_nxt    = 1'b1;
            done_nxt  = 1'b1;
            state_nxt = IDLE;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end

        default: begin
          tx_nxt    = 1'b1;
          state_nxt = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_tx.sv
// tb_nibble_serial_tx
// Directed bench for nibble_serial_tx. One instance runs with 4 clocks per
// bit, a second with 1 clock per bit. Outputs are sampled on the falling
// edge and inputs are changed there too, well away from the rising edge.
module tb_nibble_serial_tx;

  logic       clk;
  logic       reset;
  logic       enable;
  logic [3:0] d_in;
  logic       d_valid;
  logic       d_ready;
  logic       tx;
  logic       busy;
  logic       done;

  logic [3:0] d_in1;
  logic       d_valid1;
  logic       d_ready1;
  logic       tx1;
  logic       busy1;
  logic       done1;

  int checkCount = 0;
  int passCount  = 0;

  nibble_serial_tx #(.DATA_W(4), .CLKS_PER_BIT(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .enable  (enable),
    .d_in    (d_in),
    .d_valid (d_valid),
    .d_ready (d_ready),
    .tx      (tx),
    .busy    (busy),
    .done    (done)
  );

  nibble_serial_tx #(.DATA_W(4), .CLKS_PER_BIT(1)) dut1 (
    .clk     (clk),
    .reset   (reset),
    .enable  (enable),
    .d_in    (d_in1),
    .d_valid (d_valid1),
    .d_ready (d_ready1),
    .tx      (tx1),
    .busy    (busy1),
    .done    (done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Guard against a hung run.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
  endtask

  task automatic applyStimulus(input logic valid, input logic [3:0] word);
    d_valid = valid;
    d_in    = word;
  endtask

  // Expected line level at position pos (0-based) of a frame.
  function automatic logic expTx(input logic [3:0] w, input int pos, input int cpb);
    int k;
    k = pos / cpb;
    if (k == 0) return 1'b0;
    if (k <= 4) return w[k-1];
    return 1'b1;
  endfunction

  // Caller has just put a word on d_in with d_valid high at a falling edge;
  // the next rising edge is the handshake. Checks the 24 frame cycles and
  // the done cycle. Optional: keep valid high and present nextWord in the
  // idle cycle, freeze enable for 7 cycles after cycle stallAt, or pulse a
  // different word on d_in during cycle intrudeAt.
  task automatic checkFrame(input logic [3:0] word, input string tag, input bit chain,
                            input logic [3:0] nextWord, input int stallAt,
                            input int intrudeAt);
    checkOutput({tag, " ready before"}, d_ready, 1);
    for (int c = 1; c <= 25; c++) begin
      @(negedge clk);
      if (c <= 24) begin
        checkOutput($sformatf("%s tx c%0d", tag, c), tx, expTx(word, c - 1, 4));
        checkOutput($sformatf("%s busy c%0d", tag, c), busy, 1);
        checkOutput($sformatf("%s ready c%0d", tag, c), d_ready, 0);
        checkOutput($sformatf("%s done c%0d", tag, c), done, 0);
      end else begin
        checkOutput({tag, " end tx"}, tx, 1);
        checkOutput({tag, " end busy"}, busy, 0);
        checkOutput({tag, " end done"}, done, 1);
        checkOutput({tag, " end ready"}, d_ready, 1);
      end
      if (c == 1 && !chain) applyStimulus(1'b0, word);
      if (c == 25 && chain) applyStimulus(1'b1, nextWord);
      if (c == intrudeAt) applyStimulus(1'b1, ~word);
      if (c == intrudeAt + 1) applyStimulus(1'b0, word);
      if (c == stallAt) begin
        enable = 1'b0;
        for (int s = 1; s <= 7; s++) begin
          @(negedge clk);
          checkOutput($sformatf("%s stall tx s%0d", tag, s), tx, expTx(word, c - 1, 4));
          checkOutput($sformatf("%s stall busy s%0d", tag, s), busy, 1);
          checkOutput($sformatf("%s stall ready s%0d", tag, s), d_ready, 0);
        end
        enable = 1'b1;
      end
    end
  endtask

  initial begin
    reset    = 1'b0;
    enable   = 1'b1;
    d_in     = 4'h0;
    d_valid  = 1'b0;
    d_in1    = 4'h0;
    d_valid1 = 1'b0;

    // Power-up reset values.
    repeat (2) @(negedge clk);
    checkOutput("por tx", tx, 1);
    checkOutput("por busy", busy, 0);
    checkOutput("por done", done, 0);
    checkOutput("por ready", d_ready, 0);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("idle ready", d_ready, 1);
    checkOutput("idle tx", tx, 1);

    // Single frame of 4'b1011 with a one-cycle valid.
    applyStimulus(1'b1, 4'b1011);
    checkFrame(4'b1011, "f1011", 1'b0, 4'h0, 0, 0);
    @(negedge clk);
    checkOutput("f1011 after done", done, 0);
    checkOutput("f1011 after busy", busy, 0);

    // Back-to-back: valid held high across 4'hA then 4'h5.
    applyStimulus(1'b1, 4'hA);
    checkFrame(4'hA, "b2bA", 1'b1, 4'h5, 0, 0);
    checkFrame(4'h5, "b2b5", 1'b0, 4'h0, 0, 0);
    @(negedge clk);
    checkOutput("b2b idle tx", tx, 1);
    checkOutput("b2b idle busy", busy, 0);

    // Enable dropped for 7 cycles in the middle of DATA bit 2.
    applyStimulus(1'b1, 4'h4);
    checkFrame(4'h4, "stall", 1'b0, 4'h0, 14, 0);
    @(negedge clk);

    // Word change and valid pulse while busy must be ignored.
    applyStimulus(1'b1, 4'h9);
    checkFrame(4'h9, "intr", 1'b0, 4'h0, 0, 10);
    @(negedge clk);
    checkOutput("intr no refire busy", busy, 0);
    checkOutput("intr no refire tx", tx, 1);

    // Mid-sim reset during START: outputs go to reset values before any edge.
    applyStimulus(1'b1, 4'h3);
    @(negedge clk);
    applyStimulus(1'b0, 4'h3);
    @(negedge clk);
    checkOutput("rst1 pre tx", tx, 0);
    #1 reset = 1'b0;
    #1;
    checkOutput("rst1 tx", tx, 1);
    checkOutput("rst1 busy", busy, 0);
    checkOutput("rst1 done", done, 0);
    checkOutput("rst1 ready", d_ready, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("rst1 after ready", d_ready, 1);

    // Reset in the middle of the STOP bit: no done pulse, next word is clean.
    applyStimulus(1'b1, 4'hE);
    for (int c = 1; c <= 22; c++) begin
      @(negedge clk);
      checkOutput($sformatf("rst2 tx c%0d", c), tx, expTx(4'hE, c - 1, 4));
      if (c == 1) applyStimulus(1'b0, 4'hE);
    end
    #1 reset = 1'b0;
    #1;
    checkOutput("rst2 tx", tx, 1);
    checkOutput("rst2 busy", busy, 0);
    checkOutput("rst2 done", done, 0);
    for (int s = 1; s <= 2; s++) begin
      @(negedge clk);
      checkOutput($sformatf("rst2 hold done s%0d", s), done, 0);
      checkOutput($sformatf("rst2 hold tx s%0d", s), tx, 1);
    end
    reset = 1'b1;
    @(negedge clk);
    checkOutput("rst2 release done", done, 0);
    applyStimulus(1'b1, 4'h5);
    checkFrame(4'h5, "rst2 next", 1'b0, 4'h0, 0, 0);
    @(negedge clk);

    // One clock per bit: 4'h6 gives 0,0,1,1,0,1.
    checkOutput("cpb1 ready", d_ready1, 1);
    d_in1    = 4'h6;
    d_valid1 = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      checkOutput($sformatf("cpb1 tx c%0d", c), tx1, expTx(4'h6, c - 1, 1));
      checkOutput($sformatf("cpb1 busy c%0d", c), busy1, 1);
      if (c == 1) d_valid1 = 1'b0;
    end
    @(negedge clk);
    checkOutput("cpb1 done", done1, 1);
    checkOutput("cpb1 end tx", tx1, 1);
    checkOutput("cpb1 end busy", busy1, 0);
    @(negedge clk);
    checkOutput("cpb1 done clear", done1, 0);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
